// File: rtl/max_pool_engine.sv
// ============================================================================
// Module   : max_pool_engine
// Summary  : Snapshots a signed IN_DIM x IN_DIM map on start, scans it one
//            element per cycle and writes the non-overlapping POOL x POOL max.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module max_pool_engine #(
    parameter int DATA_W = 32,
    parameter int IN_DIM = 6,
    parameter int POOL   = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [IN_DIM*IN_DIM*DATA_W-1:0]                   input_fm,
    output logic [(IN_DIM/POOL)*(IN_DIM/POOL)*DATA_W-1:0]     output_fm,
    output logic                                              done,
    output logic                                              busy
);

    localparam int OUT_DIM = IN_DIM / POOL;
    localparam int NE      = IN_DIM * IN_DIM;
    localparam int NO      = OUT_DIM * OUT_DIM;
    localparam int AW      = (NE > 1) ? $clog2(NE) : 1;
    localparam int OW      = (NO > 1) ? $clog2(NO) : 1;
    localparam int WW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int KW      = (POOL > 1) ? $clog2(POOL) : 1;

    generate
        if (IN_DIM % POOL != 0) begin : g_bad_pool
            $error("max_pool_engine: IN_DIM must be a multiple of POOL");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state;
    logic signed [DATA_W-1:0]   snap [NE];
    logic        [WW-1:0]       wr, wc;
    logic        [KW-1:0]       kr, kc;
    logic signed [DATA_W-1:0]   run_max;

    logic        [AW-1:0]       elem_idx;
    logic        [OW-1:0]       out_idx;
    logic signed [DATA_W-1:0]   elem;
    logic signed [DATA_W-1:0]   win_max;
    logic                       win_first, win_last, grid_last;

    always_comb begin
        elem_idx  = AW'((int'(wr) * POOL + int'(kr)) * IN_DIM + int'(wc) * POOL + int'(kc));
        out_idx   = OW'(int'(wr) * OUT_DIM + int'(wc));
        elem      = snap[elem_idx];
        win_first = (kr == '0) && (kc == '0);
        win_last  = (kr == KW'(POOL - 1)) && (kc == KW'(POOL - 1));
        grid_last = (wr == WW'(OUT_DIM - 1)) && (wc == WW'(OUT_DIM - 1));
        // Strictly-greater replace keeps the first-scanned element on a tie.
        if (win_first || (elem > run_max)) begin
            win_max = elem;
        end else begin
            win_max = run_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            busy      <= 1'b0;
            output_fm <= '0;
            wr        <= '0;
            wc        <= '0;
            kr        <= '0;
            kc        <= '0;
            run_max   <= '0;
            for (int k = 0; k < NE; k++) begin
                snap[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < NE; k++) begin
                            snap[k] <= input_fm[k*DATA_W +: DATA_W];
                        end
                        wr      <= '0;
                        wc      <= '0;
                        kr      <= '0;
                        kc      <= '0;
                        run_max <= '0;
                        busy    <= 1'b1;
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (win_last) begin
                        output_fm[out_idx*DATA_W +: DATA_W] <= win_max;
                        kr <= '0;
                        kc <= '0;
                        if (grid_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (wc == WW'(OUT_DIM - 1)) begin
                            wc <= '0;
                            wr <= wr + 1'b1;
                        end else begin
                            wc <= wc + 1'b1;
                        end
                    end else begin
                        run_max <= win_max;
                        if (kc == KW'(POOL - 1)) begin
                            kc <= '0;
                            kr <= kr + 1'b1;
                        end else begin
                            kc <= kc + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_max_pool_engine.sv
// ============================================================================
// Module   : tb_max_pool_engine
// Summary  : Self-checking bench for max_pool_engine (default parameters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_max_pool_engine;

    localparam int DW  = 32;
    localparam int ID  = 6;
    localparam int PL  = 2;
    localparam int OD  = ID / PL;
    localparam int LAT = ID * ID;

    typedef logic [ID*ID*DW-1:0] in_t;
    typedef logic [OD*OD*DW-1:0] out_t;

    typedef struct packed {
        logic [2:0] kind;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    in_t  input_fm = '0;
    out_t output_fm;
    logic done, busy;

    int tests = 0;
    int fails = 0;

    max_pool_engine #(.DATA_W(DW), .IN_DIM(ID), .POOL(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .input_fm(input_fm),
        .output_fm(output_fm), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic check_fm(input string nm, input out_t exp);
        tests++;
        if (output_fm !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, output_fm, exp);
        end
    endtask

    // Reference: plain window-by-window signed maximum over an integer array.
    function automatic out_t pool_ref(input in_t m);
        int   v [ID*ID];
        int   best;
        out_t r;
        for (int k = 0; k < ID*ID; k++) v[k] = int'(m[k*DW +: DW]);
        r = '0;
        for (int orow = 0; orow < OD; orow++) begin
            for (int ocol = 0; ocol < OD; ocol++) begin
                best = v[(orow*PL)*ID + ocol*PL];
                for (int r0 = 0; r0 < PL; r0++)
                    for (int c0 = 0; c0 < PL; c0++)
                        if (v[(orow*PL+r0)*ID + ocol*PL+c0] > best)
                            best = v[(orow*PL+r0)*ID + ocol*PL+c0];
                r[(orow*OD+ocol)*DW +: DW] = best;
            end
        end
        return r;
    endfunction

    function automatic out_t pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        out_t r;
        r[0*DW +: DW] = a0; r[1*DW +: DW] = a1; r[2*DW +: DW] = a2;
        r[3*DW +: DW] = a3; r[4*DW +: DW] = a4; r[5*DW +: DW] = a5;
        r[6*DW +: DW] = a6; r[7*DW +: DW] = a7; r[8*DW +: DW] = a8;
        return r;
    endfunction

    function automatic in_t make_map(input int kind);
        in_t m;
        for (int k = 0; k < ID*ID; k++) begin
            case (kind)
                0:       m[k*DW +: DW] = k;
                1:       m[k*DW +: DW] = -(k + 1);
                2:       m[k*DW +: DW] = 5;
                3:       m[k*DW +: DW] = (k % 2 == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                default: m[k*DW +: DW] = 32'h7FFF_FFFF;
            endcase
        end
        return m;
    endfunction

    // Drive one start pulse; returns after the accepting edge.
    task automatic start_job(input in_t m);
        input_fm = m;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Counts edges until done (bounded) and cycles with busy high.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (!done && edges < 200) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    task automatic run_and_check(input string nm, input in_t m, input out_t exp);
        int e, b;
        start_job(m);
        wait_done(e, b);
        check_int({nm, "_latency"}, e, LAT);
        check_int({nm, "_busy_cycles"}, b, LAT);
        check_int({nm, "_busy_at_done"}, busy, 0);
        check_fm({nm, "_out"}, exp);
        tick();
        check_int({nm, "_done_one_cycle"}, done, 0);
        check_fm({nm, "_out_held"}, exp);
    endtask

    vec_t vecs [4];

    initial begin
        int   e, b, ndone;
        in_t  m;

        vecs[0].kind = 3'd0; vecs[0].exp = pack9(7, 9, 11, 19, 21, 23, 31, 33, 35);
        vecs[1].kind = 3'd1; vecs[1].exp = pack9(-1, -3, -5, -13, -15, -17, -25, -27, -29);
        vecs[2].kind = 3'd2; vecs[2].exp = pack9(5, 5, 5, 5, 5, 5, 5, 5, 5);
        vecs[3].kind = 3'd3; vecs[3].exp = {OD*OD{32'h7FFF_FFFF}};

        // Reset and idle.
        repeat (3) tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) ndone++;
            check_int("idle_busy", busy, 0);
        end
        check_int("idle_no_done", ndone, 0);
        check_fm("reset_out", '0);

        // Table-driven jobs.
        foreach (vecs[i]) run_and_check($sformatf("vec%0d", i), make_map(int'(vecs[i].kind)), vecs[i].exp);

        // Start during SCAN is ignored.
        start_job(make_map(0));
        repeat (9) tick();
        start_job(make_map(4));
        wait_done(e, b);
        check_int("ignored_start_latency", e + 10, LAT);
        check_fm("ignored_start_out", vecs[0].exp);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        check_int("ignored_start_no_second_done", ndone, 0);

        // Reset mid-SCAN aborts the job.
        start_job(make_map(0));
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_fm("abort_out_cleared", '0);
        check_int("abort_busy", busy, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        check_int("abort_no_done", ndone, 0);
        run_and_check("after_abort", make_map(2), vecs[2].exp);

        // Back-to-back: start in the first IDLE cycle after done.
        start_job(make_map(0));
        wait_done(e, b);
        check_fm("b2b_first_out", vecs[0].exp);
        tick();
        m = make_map(1);
        start_job(m);
        wait_done(e, b);
        check_int("b2b_gap_after_done_pulse", e + 1, LAT + 1);
        check_fm("b2b_second_out", pool_ref(m));
        tick();

        // Randomized jobs against the reference model.
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < ID*ID; k++) begin
                if (t % 2 == 0) m[k*DW +: DW] = $urandom;
                else            m[k*DW +: DW] = $urandom_range(6, 0) - 3;
            end
            run_and_check($sformatf("rand%0d", t), m, pool_ref(m));
            repeat ($urandom_range(2, 0)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
